// File: rtl/adder_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adder_operand_sequencer
// Purpose  : Valid/ready front/back end for a 4-bit combinational adder, with
//            a running accumulator and a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module adder_operand_sequencer #(
  parameter int ACC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_a,
  input  logic [3:0]           in_b,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  input  logic [3:0]           add_sum,
  input  logic                 add_carry,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_sum,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 acc_ovf,
  output logic [7:0]           result_count,
  input  logic                 clear
);

  localparam int c_SUM_W = ACC_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [3:0]           r_add_a;
  logic [3:0]           r_add_b;
  logic [4:0]           r_out_sum;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_acc_ovf;
  logic [7:0]           r_result_count;

  logic [4:0]           w_result;
  logic [c_SUM_W-1:0]   w_acc_next;

  assign w_result   = {add_carry, add_sum};
  assign w_acc_next = {1'b0, r_acc} + c_SUM_W'(w_result);

  // Handshake outputs are flops so they never depend on in_valid/out_ready;
  // in_ready also stays low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_in_ready     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_add_a        <= 4'd0;
      r_add_b        <= 4'd0;
      r_out_sum      <= 5'd0;
      r_acc          <= '0;
      r_acc_ovf      <= 1'b0;
      r_result_count <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_add_a    <= in_a;
            r_add_b    <= in_b;
            r_in_ready <= 1'b0;
            r_state    <= SETTLE;
          end
        end
        SETTLE: begin
          r_out_sum      <= w_result;
          r_acc          <= w_acc_next[ACC_WIDTH-1:0];
          r_acc_ovf      <= r_acc_ovf | w_acc_next[ACC_WIDTH];
          r_result_count <= r_result_count + 8'd1;
          r_out_valid    <= 1'b1;
          r_state        <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase

      // Clear overrides any accumulator update made in the same cycle.
      if (clear) begin
        r_acc          <= '0;
        r_acc_ovf      <= 1'b0;
        r_result_count <= 8'd0;
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign add_a        = r_add_a;
  assign add_b        = r_add_b;
  assign out_sum      = r_out_sum;
  assign acc          = r_acc;
  assign acc_ovf      = r_acc_ovf;
  assign result_count = r_result_count;

endmodule
`default_nettype wire

// File: tb/tb_adder_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_operand_sequencer
// Purpose  : Self-checking bench: vector table, random adds, corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_operand_sequencer;

  localparam int ACC_WIDTH = 8;
  localparam int c_MOD     = 1 << ACC_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_a;
  logic [3:0]           in_b;
  logic [3:0]           add_a;
  logic [3:0]           add_b;
  logic [3:0]           add_sum;
  logic                 add_carry;
  logic                 out_valid;
  logic                 out_ready;
  logic [4:0]           out_sum;
  logic [ACC_WIDTH-1:0] acc;
  logic                 acc_ovf;
  logic [7:0]           result_count;
  logic                 clear;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: plain integer accumulation.
  int m_acc = 0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    bit         clr;
    int         hold;
    logic [4:0] exp_sum;
  } vec_t;

  vec_t tbl[8];

  adder_operand_sequencer #(.ACC_WIDTH(ACC_WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_sum      (add_sum),
    .add_carry    (add_carry),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .acc          (acc),
    .acc_ovf      (acc_ovf),
    .result_count (result_count),
    .clear        (clear)
  );

  // Behavioural 4-bit adder sitting between add_a/add_b and add_sum/add_carry.
  assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_add(input logic [3:0] a, input logic [3:0] b, input bit clr);
    if (clr) begin
      model_reset();
    end else begin
      m_acc = m_acc + int'(a) + int'(b);
      if (m_acc >= c_MOD) begin
        m_acc = m_acc - c_MOD;
        m_ovf = 1'b1;
      end
      m_cnt = (m_cnt + 1) % 256;
    end
  endtask

  task automatic check_acc(input string name);
    check({name, "_acc"}, 32'(acc), 32'(m_acc));
    check({name, "_ovf"}, 32'(acc_ovf), 32'(m_ovf));
    check({name, "_cnt"}, 32'(result_count), 32'(m_cnt));
  endtask

  // One full transaction; all driving and sampling happens on negedges.
  task automatic do_add(input logic [3:0] a, input logic [3:0] b, input bit clr,
                        input int hold, input logic [4:0] exp_sum);
    logic [4:0] saved;
    int waited = 0;
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    if (!in_ready) return;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    check("add_a", 32'(add_a), 32'(a));
    check("add_b", 32'(add_b), 32'(b));
    check("settle_in_ready", 32'(in_ready), 32'd0);
    check("settle_out_valid", 32'(out_valid), 32'd0);
    clear = clr;
    @(negedge clk);
    clear = 1'b0;
    model_add(a, b, clr);
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_sum", 32'(out_sum), 32'(exp_sum));
    check_acc("capture");
    saved = out_sum;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a     = 4'($urandom_range(0, 15));
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_sum", 32'(out_sum), 32'(saved));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_no_accept", 32'(add_a), 32'(a));
      check("bp_cnt", 32'(result_count), 32'(m_cnt));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_in_ready", 32'(in_ready), 32'd1);
    check("drain_out_sum_held", 32'(out_sum), 32'(saved));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    check_acc("clear");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;

    tbl[0] = '{4'd9,  4'd8,  1'b0, 0, 5'h11};
    tbl[1] = '{4'd0,  4'd0,  1'b0, 1, 5'h00};
    tbl[2] = '{4'd15, 4'd15, 1'b0, 0, 5'h1e};
    tbl[3] = '{4'd15, 4'd1,  1'b0, 2, 5'h10};
    tbl[4] = '{4'd1,  4'd15, 1'b0, 0, 5'h10};
    tbl[5] = '{4'd7,  4'd8,  1'b1, 0, 5'h0f};
    tbl[6] = '{4'd12, 4'd3,  1'b0, 5, 5'h0f};
    tbl[7] = '{4'd15, 4'd0,  1'b0, 0, 5'h0f};

    rst = 1'b1; in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0;
    out_ready = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check_acc("rst");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      do_add(tbl[i].a, tbl[i].b, tbl[i].clr, tbl[i].hold, tbl[i].exp_sum);
      if (i == 0) begin
        check("single_acc", 32'(acc), 32'd17);
        check("single_cnt", 32'(result_count), 32'd1);
      end
    end

    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      do_add(ra, rb, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
             5'(int'(ra) + int'(rb)));
    end

    // Sixteen 15+15 adds: 9th capture wraps 270 -> 14.
    do_clear();
    for (int i = 0; i < 16; i++) begin
      do_add(4'd15, 4'd15, 1'b0, 0, 5'd30);
      if (i == 8) begin
        check("ovf9_acc", 32'(acc), 32'd14);
        check("ovf9_flag", 32'(acc_ovf), 32'd1);
      end
    end
    check("ovf_final_acc", 32'(acc), 32'd224);
    check("ovf_final_cnt", 32'(result_count), 32'd16);
    do_clear();

    // Clear coincident with SETTLE.
    do_add(4'd15, 4'd15, 1'b0, 0, 5'd30);
    do_add(4'd5, 4'd5, 1'b0, 0, 5'd10);
    check("pre_clr_acc", 32'(acc), 32'd40);
    do_add(4'd3, 4'd4, 1'b1, 1, 5'd7);
    check("clr_settle_acc", 32'(acc), 32'd0);
    check("clr_settle_cnt", 32'(result_count), 32'd0);

    // Asynchronous reset while in HOLD.
    in_valid = 1'b1; in_a = 4'd5; in_b = 4'd6;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("hold_before_rst", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd0);
    check("async_rst_out_sum", 32'(out_sum), 32'd0);
    check("async_rst_add_a", 32'(add_a), 32'd0);
    model_reset();
    check_acc("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    do_add(4'd1, 4'd1, 1'b0, 0, 5'd2);
    check("after_rst_acc", 32'(acc), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_operand_sequencer.md
# adder_operand_sequencer

- Handshaked front/back end for the 4-bit ripple-carry adder.
- Accepts operand pairs on a valid/ready input, drives the adder's `a`/`b` inputs from registers, and samples the adder's `sum`/`carry` after one settle cycle.
- Presents each 5-bit result on a valid/ready output and keeps a running accumulation with a sticky overflow flag.
- Sits directly around the adder: upstream of its operand inputs and downstream of its result outputs.

## Interface
- `ACC_WIDTH`, default 8: accumulator width in bits; must be ≥ 5.

- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operand pair valid.
- `in_ready`  out  1: block can accept an operand pair.
- `in_a`  in  4: operand A.
- `in_b`  in  4: operand B.
- `add_a`  out  4: registered operand to adder `a`.
- `add_b`  out  4: registered operand to adder `b`.
- `add_sum`  in  4: adder `sum`.
- `add_carry`  in  1: adder `carry`.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts result.
- `out_sum`  out  5: captured result `{add_carry, add_sum}`.
- `acc`  out  ACC_WIDTH: running sum of captured results, modulo 2^ACC_WIDTH.
- `acc_ovf`  out  1: sticky; set when any accumulation wraps.
- `result_count`  out  8: number of captured results, wraps 255→0.
- `clear`  in  1: synchronous clear of `acc`, `acc_ovf` and `result_count`.

## Operation
- FSM states: IDLE, SETTLE, HOLD.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`: latch `in_a`/`in_b` into `add_a`/`add_b` and go to SETTLE.
- **SETTLE:**
  - `in_ready`=0; exactly one cycle.
  - At the end of the cycle: `out_sum` ← `{add_carry, add_sum}`; `acc` ← `acc` + zero-extended `out_sum`; `result_count` += 1.
  - `acc_ovf` is set if the ACC_WIDTH-bit addition carries out.
  - Go to HOLD.
- **HOLD:**
  - `out_valid`=1 and `in_ready`=0.
  - `in_valid` is ignored.
  - On `out_ready`: go to IDLE.
- `add_a`/`add_b` hold their value until the next accept.
- `out_sum` holds its value until the next capture, including after `out_valid` drops.
- `clear`:
  - Acts in any state.
  - Wins over a coincident SETTLE update: `acc`=0, `acc_ovf`=0, `result_count`=0.
  - `out_sum` is still captured and `out_valid` still asserts.
- The adder is combinational; its output is assumed stable within the one SETTLE cycle.

## Timing
- Reset value of every output:
  - `in_ready`=0 while `rst` is high, 1 in the first cycle after release.
  - `out_valid`=0.
  - `add_a`, `add_b`, `out_sum`, `acc`, `acc_ovf`, `result_count` = 0.
  - State = IDLE.
- `rst` mid-operation clears everything immediately, asynchronously, including `out_valid` in HOLD. The pending result is lost.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid`/`out_ready` to them.
- Latency: accept at edge k; `add_a`/`add_b` valid after edge k; `out_valid`/`out_sum`/`acc` updated after edge k+1.
- Throughput: one result per 3 cycles minimum (IDLE→SETTLE→HOLD with `out_ready` held high).
- Backpressure: HOLD persists indefinitely. `out_sum`, `acc` and `result_count` stay stable while `out_valid`=1.
- `clear` asserted in HOLD affects only the accumulator fields; `out_valid`/`out_sum` are unchanged.

## Test plan
- Reset:
  - Stimulus: assert `rst` mid-stream, then release.
  - Required: all outputs 0 during reset; `in_ready`=1 the first cycle after release; `acc`=0.
- Single add (bench models the adder behaviourally):
  - Stimulus: `in_a`=9, `in_b`=8.
  - Required: `add_a`=9, `add_b`=8 after edge k; `out_valid`=1 and `out_sum`=5'h11 after edge k+1; `acc`=17; `result_count`=1.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles in HOLD while toggling `in_valid`/`in_a`.
  - Required: `out_valid` stays 1; `out_sum` unchanged; `in_ready`=0; no second accept.
- Overflow:
  - Stimulus: ACC_WIDTH=8, sixteen adds of 15+15.
  - Required: every `out_sum`=30; `acc_ovf` rises at the 9th capture (270→14); final `acc`=224, `result_count`=16. A `clear` pulse then zeroes `acc`, `acc_ovf` and `result_count`.
- Clear coincident with SETTLE:
  - Stimulus: `acc`=40, add 3+4, `clear` asserted during SETTLE.
  - Required: `out_sum`=7 and `out_valid`=1; `acc`=0, `result_count`=0.
- Reset in HOLD:
  - Stimulus: assert `rst` while `out_valid`=1.
  - Required: `out_valid` drops within the same cycle (asynchronous); after release the next add 1+1 gives `out_sum`=2, `acc`=2.
